sync_fifo_param: RTL and testbench
==================================

Name: sync_fifo_param

Overview:
- Single-clock, parametrised successor to the team's 8-bit, 8-deep FIFO.
- Configurable data width and depth.
- Adds a fill-level counter, programmable almost-full and almost-empty thresholds, and sticky overflow/underflow error flags.
- Selectable read mode: standard (registered, 1-cycle latency) or first-word-fall-through (FWFT).
- Used as a rate-matching buffer between producer and consumer logic in the same clock domain.

Parameters:
- DATA_W, 8: data word width in bits.
- ADDR_W, 3: address width; DEPTH = 2**ADDR_W entries, ADDR_W >= 2.
- AF_LEVEL, 6: o_almost_full asserts when count >= AF_LEVEL; legal range 1..DEPTH.
- AE_LEVEL, 1: o_almost_empty asserts when count <= AE_LEVEL; legal range 0..DEPTH-1.
- FWFT, 0: 0 selects standard read mode; 1 selects first-word-fall-through.

Ports:
- i_clk  in  1  clock; all logic on the rising edge.
- i_reset  in  1  asynchronous, active-high reset.
- i_wdata_in  in  DATA_W  write data.
- i_wr  in  1  write request.
- i_rd  in  1  read request (FWFT: read acknowledge).
- i_clr_err  in  1  synchronous clear of the sticky error flags.
- o_rdata_out  out  DATA_W  read data.
- o_rvalid  out  1  o_rdata_out holds valid data.
- o_rempty  out  1  FIFO empty.
- o_wfull  out  1  FIFO full.
- o_almost_full  out  1  count >= AF_LEVEL.
- o_almost_empty  out  1  count <= AE_LEVEL.
- o_count  out  ADDR_W+1  number of stored words, 0..DEPTH.
- o_overflow  out  1  sticky: a write was attempted while full.
- o_underflow  out  1  sticky: a read was attempted while empty.

Behaviour:
- Reset (asynchronous, immediate):
  - Write pointer, read pointer and count go to 0; o_rdata_out=0; o_rvalid=0.
  - o_rempty=1, o_wfull=0, o_almost_empty=1, o_almost_full=0.
  - o_overflow=0, o_underflow=0.
  - Memory contents are not reset.
  - Reset mid-operation discards all stored data; the FIFO comes out of reset empty.
- Write acceptance: wr_ok = i_wr & ~o_wfull. On wr_ok, mem[wptr] <= i_wdata_in and wptr increments, wrapping DEPTH-1 -> 0.
- Read acceptance: rd_ok = i_rd & ~o_rempty. On rd_ok, rptr increments with the same wrap.
- Count update, per edge: +1 on wr_ok only; -1 on rd_ok only; unchanged when both or neither.
- Simultaneous read and write:
  - When full: the read is accepted and the write is rejected. Count goes to DEPTH-1 and o_overflow sets.
  - When empty: the write is accepted and the read is rejected. Count goes to 1 and o_underflow sets.
- Flags are registered and computed from the next count value, so they are valid in the same cycle as o_count:
  - o_wfull = (count == DEPTH); o_rempty = (count == 0).
  - o_almost_full = (count >= AF_LEVEL); o_almost_empty = (count <= AE_LEVEL).
- Sticky error flags:
  - o_overflow sets on i_wr & o_wfull; o_underflow sets on i_rd & o_rempty.
  - Both clear only on i_reset or i_clr_err.
  - If i_clr_err coincides with a new error, the set wins.
- Standard mode (FWFT=0):
  - On rd_ok, o_rdata_out <= mem[rptr] and o_rvalid=1 for the following cycle; otherwise o_rvalid=0.
  - o_rdata_out holds its value when no read is accepted.
  - Read latency is 1 cycle.
  - A word written at edge N is readable by an i_rd sampled at edge N+1.
- FWFT mode (FWFT=1):
  - o_rdata_out = mem[rptr], driven combinationally from the register-file head; o_rvalid = ~o_rempty.
  - i_rd acknowledges the presented word; the next word appears after the edge.
  - Write-to-o_rvalid latency is 1 cycle: the edge that writes into an empty FIFO raises o_rvalid.
- Rejected writes and reads leave memory, pointers and count unchanged.

Test Plan:
- Reset, then write 0..7 with i_wr=1 for 8 cycles (DATA_W=8, ADDR_W=3) -> o_count steps 1..8; o_almost_full rises at count 6; o_wfull=1 after the 8th write; o_overflow stays 0.
- With the FIFO full, hold i_wr=1 with data 8'hAA for 1 cycle -> write rejected; o_count stays 8; o_overflow=1. Pulse i_clr_err -> o_overflow=0.
- Standard mode: read 8 words -> o_rdata_out sequence 0..7, each value 1 cycle after its i_rd; o_rempty=1 after the last read. One extra i_rd -> o_underflow=1 and o_rdata_out holds 7.
- Wrap-around: write 5, read 5, then write 8 and read 8 (data 8..15) -> data returned in order 8..15 across the pointer wrap; o_count returns to 0.
- Simultaneous i_wr and i_rd at count 4 for 10 cycles -> o_count stays 4 and data order is preserved. Same stimulus at full -> count 7; at empty -> count 1 with o_underflow=1.
- FWFT=1: write 8'h3C into the empty FIFO -> next cycle o_rvalid=1 and o_rdata_out=8'h3C with no i_rd. Assert i_rd -> o_rvalid=0 after the edge. Assert i_reset while holding 3 words -> o_count=0, o_rempty=1, o_rvalid=0 immediately.

Source files
------------

// File: rtl/sync_fifo_param.sv
// sync_fifo_param: single-clock FIFO with fill level, almost-full/empty thresholds,
// sticky overflow/underflow flags, and a standard or first-word-fall-through read port.
module sync_fifo_param #(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 3,
  parameter int AF_LEVEL = 6,
  parameter int AE_LEVEL = 1,
  parameter int FWFT     = 0
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic [DATA_W-1:0] i_wdata_in,
  input  logic              i_wr,
  input  logic              i_rd,
  input  logic              i_clr_err,
  output logic [DATA_W-1:0] o_rdata_out,
  output logic              o_rvalid,
  output logic              o_rempty,
  output logic              o_wfull,
  output logic              o_almost_full,
  output logic              o_almost_empty,
  output logic [ADDR_W:0]   o_count,
  output logic              o_overflow,
  output logic              o_underflow
);
  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] FULL_C = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] AF_C = (ADDR_W+1)'(AF_LEVEL);
  localparam logic [ADDR_W:0] AE_C = (ADDR_W+1)'(AE_LEVEL);
  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] wptr, rptr;
  logic [ADDR_W:0] count_nxt;
  logic wr_ok, rd_ok;
  always_comb begin
    wr_ok = i_wr & ~o_wfull;
    rd_ok = i_rd & ~o_rempty;
    count_nxt = o_count + (ADDR_W+1)'(wr_ok) - (ADDR_W+1)'(rd_ok);
  end
  // flags come from count_nxt so they line up with o_count
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      wptr <= '0;
      rptr <= '0;
      o_count <= '0;
      o_rempty <= 1'b1;
      o_wfull <= 1'b0;
      o_almost_full <= 1'b0;
      o_almost_empty <= 1'b1;
      o_overflow <= 1'b0;
      o_underflow <= 1'b0;
    end else begin
      wptr <= wptr + ADDR_W'(wr_ok);
      rptr <= rptr + ADDR_W'(rd_ok);
      o_count <= count_nxt;
      o_rempty <= count_nxt == '0;
      o_wfull <= count_nxt == FULL_C;
      o_almost_full <= count_nxt >= AF_C;
      o_almost_empty <= count_nxt <= AE_C;
      o_overflow <= (o_overflow & ~i_clr_err) | (i_wr & o_wfull);
      o_underflow <= (o_underflow & ~i_clr_err) | (i_rd & o_rempty);
    end
  end
  always_ff @(posedge i_clk) begin
    if (wr_ok) mem[wptr] <= i_wdata_in;
  end
  generate
    if (FWFT != 0) begin : g_fwft
      assign o_rdata_out = o_rempty ? '0 : mem[rptr];
      assign o_rvalid = ~o_rempty;
    end else begin : g_std
      always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
          o_rdata_out <= '0;
          o_rvalid <= 1'b0;
        end else begin
          o_rvalid <= rd_ok;
          if (rd_ok) o_rdata_out <= mem[rptr];
        end
      end
    end
  endgenerate
endmodule

// File: tb/tb_sync_fifo_param.sv
// tb_sync_fifo_param: directed checks of a standard-mode and an FWFT instance.
module tb_sync_fifo_param;
  logic clk = 0, rst;
  logic [7:0] s_wd, f_wd, s_rdata, f_rdata;
  logic s_wr, s_rd, s_clr, f_wr, f_rd, f_clr;
  logic s_rvalid, s_rempty, s_wfull, s_af, s_ae, s_ovf, s_udf;
  logic f_rvalid, f_rempty, f_wfull, f_af, f_ae, f_ovf, f_udf;
  logic [3:0] s_count, f_count;
  int checks = 0, failures = 0;
  always #5 clk = ~clk;
  sync_fifo_param #(.FWFT(0)) u_std (
    .i_clk(clk), .i_reset(rst), .i_wdata_in(s_wd), .i_wr(s_wr), .i_rd(s_rd), .i_clr_err(s_clr),
    .o_rdata_out(s_rdata), .o_rvalid(s_rvalid), .o_rempty(s_rempty), .o_wfull(s_wfull),
    .o_almost_full(s_af), .o_almost_empty(s_ae), .o_count(s_count),
    .o_overflow(s_ovf), .o_underflow(s_udf));
  sync_fifo_param #(.FWFT(1)) u_fwft (
    .i_clk(clk), .i_reset(rst), .i_wdata_in(f_wd), .i_wr(f_wr), .i_rd(f_rd), .i_clr_err(f_clr),
    .o_rdata_out(f_rdata), .o_rvalid(f_rvalid), .o_rempty(f_rempty), .o_wfull(f_wfull),
    .o_almost_full(f_af), .o_almost_empty(f_ae), .o_count(f_count),
    .o_overflow(f_ovf), .o_underflow(f_udf));
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic sdrv(input logic w, input logic r, input logic [7:0] d);
    s_wr = w; s_rd = r; s_wd = d;
    @(posedge clk); #1;
  endtask
  task automatic fdrv(input logic w, input logic r, input logic [7:0] d);
    f_wr = w; f_rd = r; f_wd = d;
    @(posedge clk); #1;
  endtask
  task automatic sclr();
    s_clr = 1; sdrv(0, 0, 0); s_clr = 0;
  endtask
  initial begin
    rst = 1; s_wr = 0; s_rd = 0; s_clr = 0; s_wd = 0; f_wr = 0; f_rd = 0; f_clr = 0; f_wd = 0;
    #3;
    chk("rst_count", s_count, 0);
    chk("rst_empty", s_rempty, 1);
    chk("rst_full", s_wfull, 0);
    chk("rst_ae", s_ae, 1);
    chk("rst_af", s_af, 0);
    chk("rst_rvalid", s_rvalid, 0);
    chk("rst_rdata", s_rdata, 0);
    chk("rst_ovf", s_ovf, 0);
    chk("rst_udf", s_udf, 0);
    chk("f_rst_rvalid", f_rvalid, 0);
    chk("f_rst_rdata", f_rdata, 0);
    @(posedge clk); #1 rst = 0;
    for (int i = 0; i < 8; i++) begin
      sdrv(1, 0, 8'(i));
      chk("fill_count", s_count, i + 1);
      chk("fill_af", s_af, 32'(i + 1 >= 6));
      chk("fill_ae", s_ae, 32'(i + 1 <= 1));
      chk("fill_full", s_wfull, 32'(i == 7));
      chk("fill_empty", s_rempty, 0);
      chk("fill_ovf", s_ovf, 0);
    end
    sdrv(1, 0, 8'hAA);
    chk("ovf_count", s_count, 8);
    chk("ovf_set", s_ovf, 1);
    sclr();
    chk("ovf_clr", s_ovf, 0);
    for (int i = 0; i < 8; i++) begin
      sdrv(0, 1, 0);
      chk("rd_data", s_rdata, i);
      chk("rd_valid", s_rvalid, 1);
      chk("rd_count", s_count, 7 - i);
    end
    chk("rd_empty", s_rempty, 1);
    sdrv(0, 1, 0);
    chk("udf_set", s_udf, 1);
    chk("udf_hold", s_rdata, 7);
    chk("udf_rvalid", s_rvalid, 0);
    chk("udf_count", s_count, 0);
    for (int i = 0; i < 5; i++) sdrv(1, 0, 8'(100 + i));
    for (int i = 0; i < 5; i++) begin
      sdrv(0, 1, 0);
      chk("w5_data", s_rdata, 100 + i);
    end
    for (int i = 0; i < 8; i++) sdrv(1, 0, 8'(8 + i));
    chk("wrap_full", s_wfull, 1);
    for (int i = 0; i < 8; i++) begin
      sdrv(0, 1, 0);
      chk("wrap_data", s_rdata, 8 + i);
    end
    chk("wrap_count", s_count, 0);
    sclr();
    chk("udf_clr", s_udf, 0);
    for (int i = 0; i < 4; i++) sdrv(1, 0, 8'(20 + i));
    for (int i = 0; i < 10; i++) begin
      sdrv(1, 1, 8'(24 + i));
      chk("sim4_count", s_count, 4);
      chk("sim4_data", s_rdata, 20 + i);
    end
    for (int i = 0; i < 4; i++) begin
      sdrv(0, 1, 0);
      chk("sim4_drain", s_rdata, 30 + i);
    end
    for (int i = 0; i < 8; i++) sdrv(1, 0, 8'(40 + i));
    sdrv(1, 1, 8'd99);
    chk("simf_count", s_count, 7);
    chk("simf_ovf", s_ovf, 1);
    chk("simf_data", s_rdata, 40);
    chk("simf_full", s_wfull, 0);
    for (int i = 0; i < 7; i++) begin
      sdrv(0, 1, 0);
      chk("simf_drain", s_rdata, 41 + i);
    end
    sclr();
    sdrv(1, 1, 8'd50);
    chk("sime_count", s_count, 1);
    chk("sime_udf", s_udf, 1);
    chk("sime_ovf", s_ovf, 0);
    chk("sime_rvalid", s_rvalid, 0);
    sdrv(0, 1, 0);
    chk("sime_data", s_rdata, 50);
    chk("sime_empty", s_rempty, 1);
    sdrv(0, 0, 0);
    fdrv(1, 0, 8'h3C);
    chk("f_rvalid", f_rvalid, 1);
    chk("f_data", f_rdata, 8'h3C);
    chk("f_count", f_count, 1);
    fdrv(0, 1, 0);
    chk("f_ack_rvalid", f_rvalid, 0);
    chk("f_ack_empty", f_rempty, 1);
    chk("f_ack_udf", f_udf, 0);
    for (int i = 1; i <= 4; i++) begin
      fdrv(1, 0, 8'(i));
      chk("f_head", f_rdata, 1);
    end
    fdrv(0, 1, 0);
    chk("f_next", f_rdata, 2);
    chk("f_cnt3", f_count, 3);
    f_rd = 0;
    #2 rst = 1;
    #1;
    chk("f_rst_count", f_count, 0);
    chk("f_rst_empty", f_rempty, 1);
    chk("f_rst_rv", f_rvalid, 0);
    chk("s_rst_empty", s_rempty, 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
